// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter in front of a single-port sync RAM
module mem_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [CNT_W-1:0]  conflicts
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // last_gnt_q: 1 = port B was granted last, 0 = port A
    logic              last_gnt_q, last_gnt_d;
    logic              rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic [CNT_W-1:0]  conflicts_q, conflicts_d;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Grant: a lone requester wins, contention goes to the port not served last; nothing during reset
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && req_b) begin
                gnt_a = last_gnt_q;
                gnt_b = !last_gnt_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Steer the granted port onto the single RAM port and compute next arbiter/counter state
    always_comb begin
        acc_en      = gnt_a || gnt_b;
        acc_we      = gnt_a ? we_a    : we_b;
        acc_addr    = gnt_a ? addr_a  : addr_b;
        acc_wdata   = gnt_a ? wdata_a : wdata_b;
        last_gnt_d  = last_gnt_q;
        if (gnt_a) begin
            last_gnt_d = 1'b0;
        end else if (gnt_b) begin
            last_gnt_d = 1'b1;
        end
        conflicts_d = conflicts_q;
        if (req_a && req_b && (conflicts_q != CNT_MAX)) begin
            conflicts_d = conflicts_q + CNT_ONE;
        end
    end

    // RAM array: not reset, written only on a granted write (grants are held low in reset)
    always_ff @(posedge clk) begin
        if (acc_en && acc_we) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    // Arbiter state, response registers and saturating conflict counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q  <= 1'b1;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            conflicts_q <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            rvalid_a_q  <= gnt_a;
            rvalid_b_q  <= gnt_b;
            conflicts_q <= conflicts_d;
            if (gnt_a) begin
                rdata_a_q <= we_a ? wdata_a : mem_q[addr_a];
            end
            if (gnt_b) begin
                rdata_b_q <= we_b ? wdata_b : mem_q[addr_b];
            end
        end
    end

    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign conflicts = conflicts_q;

endmodule
